// File: rtl/rv_regfile_sb_pkg.sv
// Shared definitions for the scoreboarded integer register file: RV32E defaults
// and the address-width helper.
package rv_regfile_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 16;
  localparam int REG_ZERO = 0;

  // Number of address bits needed to index n registers (at least 1).
  function automatic int addr_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rv_regfile_sb_score.sv
// Register scoreboard: one busy bit per architectural register, set by issue
// claims, cleared by write-back, wiped by flush; flags WAW claim stalls.
module rv_regfile_sb_score
  import rv_regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = 2,
  localparam int AW  = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              flush_i,
  output logic [NREG-1:0]   busy_o,
  output logic [NREG-1:0]   clr_o,
  output logic              iss_stall_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic            iss_busy;
  logic            iss_clr;

  // Out-of-range write addresses never match any a < NREG, so they clear nothing.
  always_comb begin
    clr = '0;
    for (int w = 0; w < NWR; w++) begin
      for (int a = 0; a < NREG; a++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(a))) clr[a] = 1'b1;
      end
    end
  end

  always_comb begin
    iss_busy = 1'b0;
    iss_clr  = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      if (iss_addr_i == AW'(a)) begin
        iss_busy = busy_q[a];
        iss_clr  = clr[a];
      end
    end
  end

  // A same-cycle write-back releases the register, so the claim goes through.
  assign iss_stall_o = iss_en_i & iss_busy & ~iss_clr & ~flush_i;

  always_comb begin
    set = '0;
    for (int a = 0; a < NREG; a++) begin
      if (a != REG_ZERO && iss_addr_i == AW'(a))
        set[a] = iss_en_i & ~iss_stall_o & ~flush_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       busy_q <= '0;
    else if (flush_i) busy_q <= '0;
    else              busy_q <= set | (busy_q & ~clr);
  end

  assign busy_o = busy_q;
  assign clr_o  = clr;

endmodule

// File: rtl/rv_regfile_sb.sv
// Multi-port integer register file for the dual-issue pipeline, with
// write-to-read bypass and an integrated busy scoreboard.
module rv_regfile_sb
  import rv_regfile_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  output logic                iss_stall_o,
  input  logic                flush_i
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr;

  rv_regfile_sb_score #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_score (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .iss_en_i    (iss_en_i),
    .iss_addr_i  (iss_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy),
    .clr_o       (clr),
    .iss_stall_o (iss_stall_o)
  );

  // Ascending port scan lets the highest-index writer win on a collision.
  always_comb begin
    for (int a = 0; a < NREG; a++) begin
      regs_d[a] = regs_q[a];
      if (a != REG_ZERO) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(a)))
            regs_d[a] = wr_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    logic            in_rng;
    logic            hit_busy;
    logic            hit_clr;

    assign ra = rd_addr_i[k*AW +: AW];

    // Register 0 and out-of-range addresses leave in_rng low: 0, not busy, no bypass.
    always_comb begin
      val      = '0;
      in_rng   = 1'b0;
      hit_busy = 1'b0;
      hit_clr  = 1'b0;
      for (int a = 0; a < NREG; a++) begin
        if (a != REG_ZERO && ra == AW'(a)) begin
          val      = regs_q[a];
          in_rng   = 1'b1;
          hit_busy = busy[a];
          hit_clr  = clr[a];
        end
      end
      for (int w = 0; w < NWR; w++) begin
        if ((BYPASS != 0) && in_rng && wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra))
          val = wr_data_i[w*XLEN +: XLEN];
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = val;
    assign rd_busy_o[k]              = hit_busy & ~(hit_clr & (BYPASS != 0));
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed bench for rv_regfile_sb: default RV32E/bypass instance plus a
// 20-register, non-bypassing instance for out-of-range and no-forwarding cases.
module tb_rv_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: XLEN=32, NREG=16 (AW=4), BYPASS=1
  logic [7:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [7:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_iss_en;
  logic [3:0]  a_iss_addr;
  logic        a_stall;
  logic        a_flush;

  // Instance B: NREG=20 (AW=5), BYPASS=0
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_iss_en;
  logic [4:0]  b_iss_addr;
  logic        b_stall;
  logic        b_flush;

  rv_regfile_sb dut_a (
    .clk (clk), .rst_n (rst_n),
    .rd_addr_i (a_rd_addr), .rd_data_o (a_rd_data), .rd_busy_o (a_rd_busy),
    .wr_en_i (a_wr_en), .wr_addr_i (a_wr_addr), .wr_data_i (a_wr_data),
    .iss_en_i (a_iss_en), .iss_addr_i (a_iss_addr), .iss_stall_o (a_stall),
    .flush_i (a_flush)
  );

  rv_regfile_sb #(.XLEN(32), .NREG(20), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .rd_addr_i (b_rd_addr), .rd_data_o (b_rd_data), .rd_busy_o (b_rd_busy),
    .wr_en_i (b_wr_en), .wr_addr_i (b_wr_addr), .wr_data_i (b_wr_data),
    .iss_en_i (b_iss_en), .iss_addr_i (b_iss_addr), .iss_stall_o (b_stall),
    .flush_i (b_flush)
  );

  typedef struct packed {
    logic [1:0]  we;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [3:0]  ia;
    logic        fl;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
    logic        es;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic [1:0] we, input logic [3:0] wa0, input logic [31:0] wd0,
    input logic [3:0] wa1, input logic [31:0] wd1,
    input logic ie, input logic [3:0] ia, input logic fl,
    input logic [3:0] ra0, input logic [3:0] ra1,
    input logic [31:0] ed0, input logic [31:0] ed1,
    input logic [1:0] eb, input logic es);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    a_wr_en    = v.we;
    a_wr_addr  = {v.wa1, v.wa0};
    a_wr_data  = {v.wd1, v.wd0};
    a_iss_en   = v.ie;
    a_iss_addr = v.ia;
    a_flush    = v.fl;
    a_rd_addr  = {v.ra1, v.ra0};
  endtask

  task automatic idle_b();
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_iss_en = 1'b0; b_iss_addr = '0; b_flush = 1'b0; b_rd_addr = '0;
  endtask

  initial begin
    //              we     wa0  wd0           wa1  wd1           ie ia    fl ra0  ra1  ed0           ed1           eb     es
    tbl[0]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd0, 4'd5, 32'h0,        32'h0,        2'b00, 0);
    tbl[1]  = mk(2'b01, 4'd5, 32'h12345678, 4'd0, 32'h0,        0, 4'd0, 0, 4'd5, 4'd5, 32'h12345678, 32'h12345678, 2'b00, 0);
    tbl[2]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd5, 4'd5, 32'h12345678, 32'h12345678, 2'b00, 0);
    tbl[3]  = mk(2'b11, 4'd3, 32'hAAAAAAAA, 4'd3, 32'h55555555, 0, 4'd0, 0, 4'd3, 4'd3, 32'h55555555, 32'h55555555, 2'b00, 0);
    tbl[4]  = mk(2'b01, 4'd0, 32'hFFFFFFFF, 4'd0, 32'h0,        0, 4'd0, 0, 4'd3, 4'd0, 32'h55555555, 32'h0,        2'b00, 0);
    tbl[5]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd0, 4'd3, 32'h0,        32'h55555555, 2'b00, 0);
    tbl[6]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd7, 0, 4'd7, 4'd7, 32'h0,        32'h0,        2'b00, 0);
    tbl[7]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd7, 0, 4'd7, 4'd7, 32'h0,        32'h0,        2'b11, 1);
    tbl[8]  = mk(2'b01, 4'd7, 32'h77,       4'd0, 32'h0,        1, 4'd7, 0, 4'd7, 4'd5, 32'h77,       32'h12345678, 2'b00, 0);
    tbl[9]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd7, 4'd7, 32'h77,       32'h77,       2'b11, 0);
    tbl[10] = mk(2'b10, 4'd0, 32'h0,        4'd7, 32'h88,       0, 4'd0, 0, 4'd7, 4'd7, 32'h88,       32'h88,       2'b00, 0);
    tbl[11] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd7, 4'd7, 32'h88,       32'h88,       2'b00, 0);
    tbl[12] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd2, 0, 4'd2, 4'd4, 32'h0,        32'h0,        2'b00, 0);
    tbl[13] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd4, 0, 4'd2, 4'd4, 32'h0,        32'h0,        2'b01, 0);
    tbl[14] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd6, 0, 4'd4, 4'd6, 32'h0,        32'h0,        2'b01, 0);
    tbl[15] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd9, 1, 4'd2, 4'd6, 32'h0,        32'h0,        2'b11, 0);
    tbl[16] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd2, 4'd9, 32'h0,        32'h0,        2'b00, 0);
    tbl[17] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd0, 0, 4'd6, 4'd4, 32'h0,        32'h0,        2'b00, 0);
    tbl[18] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1, 4'd0, 0, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 0);
    tbl[19] = mk(2'b01, 4'd6, 32'hCAFE,     4'd0, 32'h0,        0, 4'd0, 0, 4'd6, 4'd0, 32'hCAFE,     32'h0,        2'b00, 0);
    tbl[20] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        0, 4'd0, 0, 4'd6, 4'd6, 32'hCAFE,     32'hCAFE,     2'b00, 0);

    rst_n = 1'b0;
    drive_a(tbl[0]);
    idle_b();

    // Reset state on every address of instance A
    #2;
    for (int r = 0; r < 16; r++) begin
      a_rd_addr = {4'(r), 4'(r)};
      #1;
      chk($sformatf("reset r%0d data0", r), a_rd_data[31:0], 32'h0);
      chk($sformatf("reset r%0d data1", r), a_rd_data[63:32], 32'h0);
      chk($sformatf("reset r%0d busy", r), {30'h0, a_rd_busy}, 32'h0);
    end
    chk("reset stall", {31'h0, a_stall}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_a(tbl[i]);
      #2;
      chk($sformatf("v%0d data0", i), a_rd_data[31:0], tbl[i].ed0);
      chk($sformatf("v%0d data1", i), a_rd_data[63:32], tbl[i].ed1);
      chk($sformatf("v%0d busy", i), {30'h0, a_rd_busy}, {30'h0, tbl[i].eb});
      chk($sformatf("v%0d stall", i), {31'h0, a_stall}, {31'h0, tbl[i].es});
    end
    @(negedge clk);
    drive_a(tbl[0]);

    // Instance B: no forwarding, old value in the write cycle
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd5}; b_wr_data = {32'h0, 32'h12345678};
    b_rd_addr = {5'd5, 5'd5};
    #2;
    chk("nobyp same-cycle", b_rd_data[63:32], 32'h0);
    @(negedge clk);
    idle_b(); b_rd_addr = {5'd5, 5'd5};
    #2;
    chk("nobyp next-cycle", b_rd_data[63:32], 32'h12345678);

    // Out-of-range write must not alias onto reg 4
    @(negedge clk);
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd4}; b_wr_data = {32'h0, 32'h44};
    @(negedge clk);
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd20}; b_wr_data = {32'h0, 32'hDEAD};
    b_rd_addr = {5'd20, 5'd4};
    #2;
    chk("oor r4 before", b_rd_data[31:0], 32'h44);
    chk("oor r20 data", b_rd_data[63:32], 32'h0);
    @(negedge clk);
    idle_b(); b_rd_addr = {5'd20, 5'd4};
    #2;
    chk("oor r4 after", b_rd_data[31:0], 32'h44);
    chk("oor r20 after", b_rd_data[63:32], 32'h0);
    chk("oor busy", {30'h0, b_rd_busy}, 32'h0);

    // Out-of-range claim is ignored
    @(negedge clk);
    b_iss_en = 1'b1; b_iss_addr = 5'd20;
    @(negedge clk);
    b_iss_en = 1'b1; b_iss_addr = 5'd20; b_rd_addr = {5'd20, 5'd20};
    #2;
    chk("oor claim stall", {31'h0, b_stall}, 32'h0);
    chk("oor claim busy", {30'h0, b_rd_busy}, 32'h0);

    // Without bypass, a write-back cycle still reports the register busy
    @(negedge clk);
    idle_b(); b_iss_en = 1'b1; b_iss_addr = 5'd7;
    @(negedge clk);
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd7}; b_wr_data = {32'h0, 32'h70};
    b_iss_en = 1'b1; b_iss_addr = 5'd7; b_rd_addr = {5'd0, 5'd7};
    #2;
    chk("nobyp wb data", b_rd_data[31:0], 32'h0);
    chk("nobyp wb busy", {31'h0, b_rd_busy[0]}, 32'h1);
    chk("nobyp reclaim stall", {31'h0, b_stall}, 32'h0);
    @(negedge clk);
    idle_b(); b_rd_addr = {5'd0, 5'd7};
    #2;
    chk("nobyp r7 data", b_rd_data[31:0], 32'h70);
    chk("nobyp r7 busy", {31'h0, b_rd_busy[0]}, 32'h1);

    // Asynchronous reset mid-run
    @(negedge clk);
    a_iss_en = 1'b1; a_iss_addr = 4'd8; a_rd_addr = {4'd8, 4'd5};
    @(negedge clk);
    a_iss_en = 1'b0;
    #2;
    chk("pre-rst r5", a_rd_data[31:0], 32'h12345678);
    chk("pre-rst busy", {30'h0, a_rd_busy}, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst r5", a_rd_data[31:0], 32'h0);
    chk("async rst busy", {30'h0, a_rd_busy}, 32'h0);
    chk("async rst b r7", b_rd_data[31:0], 32'h0);
    chk("async rst b busy", {30'h0, b_rd_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_iss_en = 1'b1; a_iss_addr = 4'd8;
    #2;
    chk("post-rst stall", {31'h0, a_stall}, 32'h0);
    @(negedge clk);
    a_iss_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
